multicycle_control_unit: RTL and testbench

Multi-cycle RV32 control FSM: the successor to the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the shared-ALU/shared-memory datapath select and enable lines. It waits on a memory ready handshake, adds I-type ALU and JAL support, flags illegal opcodes, and counts retired instructions.

---
 rtl/riscv_ctrl_pkg.sv | 60 ++++++
 rtl/ctrl_output_decode.sv | 110 +++++++++++
 rtl/multicycle_control_unit.sv | 127 ++++++++++++
 tb/tb_multicycle_control_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
// Shared definitions for the multi-cycle RV32 control unit: the opcode
// constants it dispatches on, the 4-bit state encoding (also visible on
// the debug state port) and the encodings of the datapath select fields.
// Ports: none (package).

package riscv_ctrl_pkg;

  // Major opcodes (instr[6:0]) understood by the sequencer
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_MEM_ADDR = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WB   = 4'd6,
    ST_MEM_WR   = 4'd7,
    ST_ALU_WB   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_ILLEGAL  = 4'd11
  } state_t;

  // alu_op encodings
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_RFUNCT = 2'b10;
  localparam logic [1:0] ALU_IFUNCT = 2'b11;

  // mem_to_reg encodings
  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  // alu_src_a encodings
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLD_PC = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;

  // alu_src_b encodings
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // True for the last state of every instruction; leaving one of these
  // for FETCH is what retires an instruction.
  function automatic logic is_final_state(state_t s);
    return (s == ST_MEM_WB) || (s == ST_MEM_WR) || (s == ST_ALU_WB) ||
           (s == ST_BRANCH) || (s == ST_JAL);
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// ctrl_output_decode
// Combinational map from the sequencer state to the datapath control lines.
// Purely Moore except that FETCH qualifies pc_write/ir_write with the
// memory handshake and BRANCH qualifies pc_write with the comparator.
// Ports:
//   state        in  4  current sequencer state
//   mem_ready    in  1  effective memory-ready (already forced high when
//                       the handshake is disabled)
//   branch_cond  in  1  branch comparator result
//   pc_write .. pc_src  out  control lines, see the top-level header

module ctrl_output_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       branch_cond,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_src
);

  // Everything defaults to 0 so each state only lists what it asserts;
  // ILLEGAL and the unused encodings therefore drive all enables low.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = WB_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    pc_src     = 1'b0;
    case (state_t'(state))
      ST_FETCH: begin
        // PC+4 is computed while the instruction is read; PC and IR are
        // only loaded once the read actually completes.
        mem_read  = 1'b1;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      ST_DECODE: begin
        // Speculatively form the branch/JAL target (old PC + imm) in ALUOut
        alu_src_a = SRCA_OLD_PC;
        alu_src_b = SRCB_IMM;
      end
      ST_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALU_RFUNCT;
      end
      ST_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_IFUNCT;
      end
      ST_MEM_ADDR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = WB_MDR;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      ST_ALU_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = WB_ALUOUT;
      end
      ST_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALU_BRANCH;
        pc_src    = 1'b1;
        pc_write  = branch_cond;
      end
      ST_JAL: begin
        // Link value is the already-incremented PC; target sits in ALUOut
        reg_write  = 1'b1;
        mem_to_reg = WB_PC;
        pc_write   = 1'b1;
        pc_src     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Multi-cycle RV32 control FSM. Sequences each instruction through fetch,
// decode, execute, memory and writeback, waits on the memory handshake,
// flags illegal opcodes (sticky until reset) and counts retired
// instructions.
// Parameters:
//   MEM_HS  1 = stall on mem_ready, 0 = single-cycle memory (mem_ready ignored)
//   CNT_W   width of the retired-instruction counter
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   opcode            instr[6:0] from the IR
//   branch_cond       comparator result for the current branch
//   mem_ready         memory access completes this cycle
//   pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
//   mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src   datapath controls
//   illegal           sticky illegal-opcode flag
//   retired           completed-instruction count (wraps)
//   state             current state, for debug

module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter bit MEM_HS = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             branch_cond,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_src,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  state_t           state_q;
  state_t           state_next;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;
  logic             ready_eff;
  logic             dec_pc_write;
  logic             dec_ir_write;

  assign ready_eff = MEM_HS ? mem_ready : 1'b1;

  // Next-state logic; memory states hold until the access completes
  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_FETCH:    if (ready_eff) state_next = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:           state_next = ST_EXEC_R;
          OP_ITYPE:           state_next = ST_EXEC_I;
          OP_LOAD, OP_STORE:  state_next = ST_MEM_ADDR;
          OP_BRANCH:          state_next = ST_BRANCH;
          OP_JAL:             state_next = ST_JAL;
          default:            state_next = ST_ILLEGAL;
        endcase
      end
      ST_EXEC_R:   state_next = ST_ALU_WB;
      ST_EXEC_I:   state_next = ST_ALU_WB;
      ST_MEM_ADDR: state_next = (opcode == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (ready_eff) state_next = ST_MEM_WB;
      ST_MEM_WB:   state_next = ST_FETCH;
      ST_MEM_WR:   if (ready_eff) state_next = ST_FETCH;
      ST_ALU_WB:   state_next = ST_FETCH;
      ST_BRANCH:   state_next = ST_FETCH;
      ST_JAL:      state_next = ST_FETCH;
      ST_ILLEGAL:  state_next = ST_ILLEGAL;
      default:     state_next = ST_FETCH;
    endcase
  end

  // State register, sticky illegal flag and retire counter. The counter
  // only advances on the final transition, so an instruction abandoned by
  // reset is never counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_next;
      if (state_next == ST_ILLEGAL) illegal_q <= 1'b1;
      if (state_next == ST_FETCH && is_final_state(state_q))
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  ctrl_output_decode u_decode (
    .state       (state_q),
    .mem_ready   (ready_eff),
    .branch_cond (branch_cond),
    .pc_write    (dec_pc_write),
    .ir_write    (dec_ir_write),
    .i_or_d      (i_or_d),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .pc_src      (pc_src)
  );

  // FETCH would otherwise load PC/IR on a ready memory while reset is held
  assign pc_write = dec_pc_write & rst_n;
  assign ir_write = dec_ir_write & rst_n;

  assign illegal = illegal_q;
  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit
// Directed bench with a scoreboard. dut_a (handshake on, 3-bit counter)
// runs a mix of instructions including counter wrap, reset during a store
// wait and the illegal trap; dut_b (handshake off) runs a store with
// mem_ready tied low.

module tb_multicycle_control_unit;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2,
                         S_EXEC_I = 4'd3, S_MEM_ADDR = 4'd4, S_MEM_RD = 4'd5,
                         S_MEM_WB = 4'd6, S_MEM_WR = 4'd7, S_ALU_WB = 4'd8,
                         S_BRANCH = 4'd9, S_JAL = 4'd10, S_ILLEGAL = 4'd11;

  localparam logic [6:0] O_R = 7'b0110011, O_I = 7'b0010011,
                         O_LD = 7'b0000011, O_ST = 7'b0100011,
                         O_BR = 7'b1100011, O_JAL = 7'b1101111,
                         O_BAD = 7'b1111111;

  typedef struct packed {
    logic        which;
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic [31:0] ret;
    logic        ill;
  } exp_t;

  logic clk;
  logic rst_n, rst_n_b;
  logic [6:0] opcode, opcode_b;
  logic branch_cond, mem_ready;
  logic mem_ready_b;

  logic pcw_a, irw_a, iod_a, mr_a, mw_a, rw_a, ps_a, ill_a;
  logic [1:0] m2r_a, sa_a, sb_a, op_a;
  logic [2:0] ret_a;
  logic [3:0] st_a;

  logic pcw_b, irw_b, iod_b, mr_b, mw_b, rw_b, ps_b, ill_b;
  logic [1:0] m2r_b, sa_b, sb_b, op_b;
  logic [31:0] ret_b;
  logic [3:0] st_b;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  logic [2:0]  model_ret;
  logic [31:0] model_ret_b;

  assign mem_ready_b = 1'b0;

  multicycle_control_unit #(.MEM_HS(1'b1), .CNT_W(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_cond(branch_cond),
    .mem_ready(mem_ready), .pc_write(pcw_a), .ir_write(irw_a),
    .i_or_d(iod_a), .mem_read(mr_a), .mem_write(mw_a), .reg_write(rw_a),
    .mem_to_reg(m2r_a), .alu_src_a(sa_a), .alu_src_b(sb_a), .alu_op(op_a),
    .pc_src(ps_a), .illegal(ill_a), .retired(ret_a), .state(st_a)
  );

  multicycle_control_unit #(.MEM_HS(1'b0), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .opcode(opcode_b), .branch_cond(1'b0),
    .mem_ready(mem_ready_b), .pc_write(pcw_b), .ir_write(irw_b),
    .i_or_d(iod_b), .mem_read(mr_b), .mem_write(mw_b), .reg_write(rw_b),
    .mem_to_reg(m2r_b), .alu_src_a(sa_b), .alu_src_b(sb_b), .alu_op(op_b),
    .pc_src(ps_b), .illegal(ill_b), .retired(ret_b), .state(st_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference table of control outputs per state, packed as
  // {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
  //  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src}
  function automatic logic [15:0] exp_ctrl(logic [3:0] st, logic rdy, logic bc);
    logic pcw, irw, iod, mr, mw, rw, ps;
    logic [1:0] m2r, sa, sbb, op;
    {pcw, irw, iod, mr, mw, rw, ps} = 7'b0;
    {m2r, sa, sbb, op} = 8'b0;
    case (st)
      S_FETCH:    begin mr = 1'b1; sbb = 2'b01; pcw = rdy; irw = rdy; end
      S_DECODE:   begin sa = 2'b01; sbb = 2'b10; end
      S_EXEC_R:   begin sa = 2'b10; sbb = 2'b00; op = 2'b10; end
      S_EXEC_I:   begin sa = 2'b10; sbb = 2'b10; op = 2'b11; end
      S_MEM_ADDR: begin sa = 2'b10; sbb = 2'b10; op = 2'b00; end
      S_MEM_RD:   begin mr = 1'b1; iod = 1'b1; end
      S_MEM_WB:   begin rw = 1'b1; m2r = 2'b01; end
      S_MEM_WR:   begin mw = 1'b1; iod = 1'b1; end
      S_ALU_WB:   begin rw = 1'b1; m2r = 2'b00; end
      S_BRANCH:   begin sa = 2'b10; op = 2'b01; ps = 1'b1; pcw = bc; end
      S_JAL:      begin rw = 1'b1; m2r = 2'b10; pcw = 1'b1; ps = 1'b1; end
      default:    ;
    endcase
    return {pcw, irw, iod, mr, mw, rw, m2r, sa, sbb, op, ps};
  endfunction

  task automatic checkOutput(input string tag);
    exp_t e;
    logic [15:0] oc;
    logic [3:0]  os;
    logic [31:0] orr;
    logic        oi;
    if (sb.size() == 0) begin
      failures++;
      $error("[TB] FAIL %s scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    if (e.which) begin
      oc = {pcw_b, irw_b, iod_b, mr_b, mw_b, rw_b, m2r_b, sa_b, sb_b, op_b, ps_b};
      os = st_b; orr = ret_b; oi = ill_b;
    end else begin
      oc = {pcw_a, irw_a, iod_a, mr_a, mw_a, rw_a, m2r_a, sa_a, sb_a, op_a, ps_a};
      os = st_a; orr = {29'b0, ret_a}; oi = ill_a;
    end
    checks++;
    assert (os === e.st) else begin
      failures++;
      $error("[TB] FAIL %s state got=%0d exp=%0d", tag, os, e.st);
    end
    checks++;
    assert (oc === e.ctrl) else begin
      failures++;
      $error("[TB] FAIL %s ctrl got=%b exp=%b (state %0d)", tag, oc, e.ctrl, e.st);
    end
    checks++;
    assert (orr === e.ret) else begin
      failures++;
      $error("[TB] FAIL %s retired got=%0d exp=%0d", tag, orr, e.ret);
    end
    checks++;
    assert (oi === e.ill) else begin
      failures++;
      $error("[TB] FAIL %s illegal got=%b exp=%b", tag, oi, e.ill);
    end
  endtask

  // Called at a falling edge: drive this cycle's inputs, record what the
  // DUT must show, compare shortly after, then move to the next falling edge.
  task automatic applyStimulus(input logic which, input logic [3:0] st,
                               input logic rdy, input logic ill, input string tag);
    exp_t e;
    if (!which) mem_ready = rdy;
    e.which = which;
    e.st    = st;
    e.ctrl  = exp_ctrl(st, rdy, which ? 1'b0 : branch_cond);
    e.ret   = which ? model_ret_b : {29'b0, model_ret};
    e.ill   = ill;
    sb.push_back(e);
    #1 checkOutput(tag);
    @(negedge clk);
  endtask

  task automatic run_instr(input string tag, input logic [6:0] op,
                           input logic bc, input int waits);
    opcode = op;
    branch_cond = bc;
    applyStimulus(1'b0, S_FETCH, 1'b1, 1'b0, tag);
    applyStimulus(1'b0, S_DECODE, 1'b0, 1'b0, tag);
    case (op)
      O_R: begin
        applyStimulus(1'b0, S_EXEC_R, 1'b0, 1'b0, tag);
        applyStimulus(1'b0, S_ALU_WB, 1'b0, 1'b0, tag);
      end
      O_I: begin
        applyStimulus(1'b0, S_EXEC_I, 1'b0, 1'b0, tag);
        applyStimulus(1'b0, S_ALU_WB, 1'b0, 1'b0, tag);
      end
      O_LD: begin
        applyStimulus(1'b0, S_MEM_ADDR, 1'b0, 1'b0, tag);
        for (int i = 0; i < waits; i++) applyStimulus(1'b0, S_MEM_RD, 1'b0, 1'b0, tag);
        applyStimulus(1'b0, S_MEM_RD, 1'b1, 1'b0, tag);
        applyStimulus(1'b0, S_MEM_WB, 1'b0, 1'b0, tag);
      end
      O_ST: begin
        applyStimulus(1'b0, S_MEM_ADDR, 1'b0, 1'b0, tag);
        for (int i = 0; i < waits; i++) applyStimulus(1'b0, S_MEM_WR, 1'b0, 1'b0, tag);
        applyStimulus(1'b0, S_MEM_WR, 1'b1, 1'b0, tag);
      end
      O_BR:  applyStimulus(1'b0, S_BRANCH, 1'b0, 1'b0, tag);
      O_JAL: applyStimulus(1'b0, S_JAL, 1'b0, 1'b0, tag);
      default: ;
    endcase
    model_ret = model_ret + 3'd1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; rst_n_b = 1'b0;
    opcode = O_R; opcode_b = O_ST;
    branch_cond = 1'b0; mem_ready = 1'b1;
    model_ret = 3'd0; model_ret_b = 32'd0;

    // Reset state: FETCH values, but PC/IR loads suppressed despite ready
    #2;
    e = '{which: 1'b0, st: S_FETCH, ctrl: exp_ctrl(S_FETCH, 1'b0, 1'b0),
          ret: 32'd0, ill: 1'b0};
    sb.push_back(e);
    checkOutput("reset");

    @(negedge clk);
    rst_n = 1'b1;

    // Nine instructions: the 3-bit counter wraps after the eighth
    run_instr("rtype", O_R, 1'b0, 0);
    run_instr("itype", O_I, 1'b0, 0);
    run_instr("load_stall", O_LD, 1'b0, 2);
    run_instr("store_stall", O_ST, 1'b0, 1);
    run_instr("branch_taken", O_BR, 1'b1, 0);
    run_instr("branch_not", O_BR, 1'b0, 0);
    run_instr("jal", O_JAL, 1'b1, 0);
    run_instr("rtype_wrap", O_R, 1'b0, 0);
    run_instr("itype_post", O_I, 1'b0, 0);

    // Store abandoned by reset while waiting on memory
    opcode = O_ST;
    applyStimulus(1'b0, S_FETCH, 1'b1, 1'b0, "abort");
    applyStimulus(1'b0, S_DECODE, 1'b0, 1'b0, "abort");
    applyStimulus(1'b0, S_MEM_ADDR, 1'b0, 1'b0, "abort");
    applyStimulus(1'b0, S_MEM_WR, 1'b0, 1'b0, "abort");
    mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    model_ret = 3'd0;
    e = '{which: 1'b0, st: S_FETCH, ctrl: exp_ctrl(S_FETCH, 1'b0, 1'b0),
          ret: 32'd0, ill: 1'b0};
    sb.push_back(e);
    #1 checkOutput("abort_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Illegal opcode traps; ready and branch_cond toggling must not matter
    opcode = O_BAD;
    applyStimulus(1'b0, S_FETCH, 1'b1, 1'b0, "illegal");
    applyStimulus(1'b0, S_DECODE, 1'b0, 1'b0, "illegal");
    for (int i = 0; i < 20; i++) begin
      branch_cond = i[0];
      applyStimulus(1'b0, S_ILLEGAL, i[1], 1'b1, "illegal_hold");
    end
    mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    e = '{which: 1'b0, st: S_FETCH, ctrl: exp_ctrl(S_FETCH, 1'b0, 1'b0),
          ret: 32'd0, ill: 1'b0};
    sb.push_back(e);
    #1 checkOutput("illegal_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("after_illegal", O_R, 1'b0, 0);

    // No handshake: store completes in 4 cycles with mem_ready tied low
    rst_n_b = 1'b1;
    applyStimulus(1'b1, S_FETCH, 1'b1, 1'b0, "nohs_store");
    applyStimulus(1'b1, S_DECODE, 1'b1, 1'b0, "nohs_store");
    applyStimulus(1'b1, S_MEM_ADDR, 1'b1, 1'b0, "nohs_store");
    applyStimulus(1'b1, S_MEM_WR, 1'b1, 1'b0, "nohs_store");
    model_ret_b = 32'd1;
    applyStimulus(1'b1, S_FETCH, 1'b1, 1'b0, "nohs_next");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
